// File: rtl/onebit_pkg.sv
// Shared types for the CELLA one-bit column sequencer: FSM state encoding and
// the per-state drive pattern for the cell pins {preb, WL, WLB, w_en, SAE}.
package onebit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_WRITE,
    ST_RD_Q,
    ST_PRE2,
    ST_RD_QB,
    ST_RESP
  } onebit_state_t;

  // Bit order: {preb, WL, WLB, w_en, SAE}
  localparam logic [4:0] OV_IDLE  = 5'b00000;
  localparam logic [4:0] OV_PRE   = 5'b00000;
  localparam logic [4:0] OV_WRITE = 5'b11110;
  localparam logic [4:0] OV_RD_Q  = 5'b11001;
  localparam logic [4:0] OV_RD_QB = 5'b10101;
  localparam logic [4:0] OV_RESP  = 5'b00000;

  function automatic logic [4:0] state_outs(input onebit_state_t s);
    case (s)
      ST_PRE, ST_PRE2: return OV_PRE;
      ST_WRITE:        return OV_WRITE;
      ST_RD_Q:         return OV_RD_Q;
      ST_RD_QB:        return OV_RD_QB;
      ST_RESP:         return OV_RESP;
      default:         return OV_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/onebit_ctrl_if.sv
// Request/response handshake between the digital requester and the one-bit
// column sequencer.
interface onebit_ctrl_if;
  logic req_valid;
  logic req_ready;
  logic req_we;
  logic req_wdata;
  logic rsp_valid;
  logic rsp_rdata;
  logic rsp_err;

  modport master (
    output req_valid, req_we, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/onebit_phase_timer.sv
// Loadable down-counter timing each sequencer phase; done is high once the
// count reaches zero (load with cycles-1).
module onebit_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] count,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (load)       cnt <= count;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/onebit_ctrl.sv
// Sequencer for one CELLA bitcell column: precharge / write / sense phases and
// sense-amp capture. Define ONEBIT_DUAL_READ_EN to add the QB read and Q/QB check.
module onebit_ctrl
  import onebit_pkg::*;
#(
  parameter int PRE_CYC = 1,
  parameter int WR_CYC  = 1,
  parameter int SA_CYC  = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  onebit_ctrl_if.slave   req,
  output logic           preb,
  output logic           WL,
  output logic           WLB,
  output logic           w_en,
  output logic           write_bit,
  output logic           SAE,
  input  logic           sa_out
);

  localparam int MAX_CYC = (PRE_CYC > WR_CYC) ?
                           ((PRE_CYC > SA_CYC) ? PRE_CYC : SA_CYC) :
                           ((WR_CYC  > SA_CYC) ? WR_CYC  : SA_CYC);
  localparam int TW = $clog2(MAX_CYC) + 1;

  onebit_state_t state, nxt;
  logic          done, load;
  logic [TW-1:0] load_val;
  logic          we_r, wd_r, q_s, q_nxt;
`ifdef ONEBIT_DUAL_READ_EN
  logic          qb_s, qb_nxt;
`endif

  onebit_phase_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .count (load_val),
    .done  (done)
  );

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  if (req.req_valid && req.req_ready) nxt = ST_PRE;
      ST_PRE:   if (done) nxt = we_r ? ST_WRITE : ST_RD_Q;
      ST_WRITE: if (done) nxt = ST_RESP;
`ifdef ONEBIT_DUAL_READ_EN
      ST_RD_Q:  if (done) nxt = ST_PRE2;
`else
      ST_RD_Q:  if (done) nxt = ST_RESP;
`endif
      ST_PRE2:  if (done) nxt = ST_RD_QB;
      ST_RD_QB: if (done) nxt = ST_RESP;
      ST_RESP:  nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  // Timer reloads on every state entry with the new phase length minus one.
  always_comb begin
    load     = (nxt != state);
    load_val = '0;
    case (nxt)
      ST_PRE, ST_PRE2:  load_val = TW'(PRE_CYC - 1);
      ST_WRITE:         load_val = TW'(WR_CYC - 1);
      ST_RD_Q, ST_RD_QB: load_val = TW'(SA_CYC - 1);
      default:          load_val = '0;
    endcase
  end

  // Sense samples are forwarded so the response can use them on the same edge.
  assign q_nxt  = (state == ST_RD_Q  && done) ? sa_out : q_s;
`ifdef ONEBIT_DUAL_READ_EN
  assign qb_nxt = (state == ST_RD_QB && done) ? sa_out : qb_s;
`endif

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && req.req_valid && req.req_ready) begin
      we_r <= req.req_we;
      wd_r <= req.req_wdata;
    end
    q_s <= q_nxt;
`ifdef ONEBIT_DUAL_READ_EN
    qb_s <= qb_nxt;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                      <= ST_IDLE;
      {preb, WL, WLB, w_en, SAE} <= OV_IDLE;
      write_bit                  <= 1'b0;
      req.req_ready              <= 1'b1;
      req.rsp_valid              <= 1'b0;
      req.rsp_rdata              <= 1'b0;
      req.rsp_err                <= 1'b0;
    end else begin
      state                      <= nxt;
      {preb, WL, WLB, w_en, SAE} <= state_outs(nxt);
      write_bit                  <= (nxt == ST_WRITE) ? wd_r : 1'b0;
      req.req_ready              <= (nxt == ST_IDLE);
      req.rsp_valid              <= (nxt == ST_RESP);
      req.rsp_rdata              <= (nxt == ST_RESP) && !we_r && q_nxt;
`ifdef ONEBIT_DUAL_READ_EN
      req.rsp_err                <= (nxt == ST_RESP) && !we_r && (q_nxt == qb_nxt);
`else
      req.rsp_err                <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_onebit_ctrl.sv
// Directed self-checking bench for onebit_ctrl: default-timing instance with a
// behavioural bitcell model, plus a PRE_CYC=3 / WR_CYC=2 instance for phase lengths.
module tb_onebit_ctrl;

`ifdef ONEBIT_DUAL_READ_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif
  localparam int RD_LAT = DUAL ? 5 : 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  onebit_ctrl_if bus ();
  onebit_ctrl_if bus2 ();

  logic preb, WL, WLB, w_en, write_bit, SAE, sa_out;
  logic preb2, WL2, WLB2, w_en2, write_bit2, SAE2;
  logic store = 1'b0;
  logic force_one = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  onebit_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req(bus),
    .preb(preb), .WL(WL), .WLB(WLB), .w_en(w_en),
    .write_bit(write_bit), .SAE(SAE), .sa_out(sa_out)
  );

  onebit_ctrl #(.PRE_CYC(3), .WR_CYC(2), .SA_CYC(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(bus2),
    .preb(preb2), .WL(WL2), .WLB(WLB2), .w_en(w_en2),
    .write_bit(write_bit2), .SAE(SAE2), .sa_out(1'b0)
  );

  // Bitcell model: stores on a full write phase, senses Q on WL, QB on WLB.
  always @(posedge clk) if (w_en && WL && WLB) store <= write_bit;
  assign sa_out = force_one ? 1'b1 :
                  (WL && !WLB) ? store :
                  (WLB && !WL) ? ~store : 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one request; returns at the negedge of cycle T+1.
  task automatic start(input bit b2, input logic we, input logic wd);
    @(negedge clk);
    if (b2) begin bus2.req_valid = 1'b1; bus2.req_we = we; bus2.req_wdata = wd; end
    else    begin bus.req_valid  = 1'b1; bus.req_we  = we; bus.req_wdata  = wd; end
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus2.req_valid = 1'b0;
  endtask

  // Called at T+1; returns at the negedge where rsp_valid is seen.
  task automatic wait_rsp(input bit b2, output int lat, output int n_pre,
                          output int n_wen, output int n_wlb);
    bit seen;
    lat = 1; n_pre = 0; n_wen = 0; n_wlb = 0; seen = 1'b0;
    while (!seen && lat < 40) begin
      seen = b2 ? bus2.rsp_valid : bus.rsp_valid;
      if (!seen) begin
        if (!(b2 ? preb2 : preb)) n_pre++;
        if (b2 ? w_en2 : w_en)    n_wen++;
        if (b2 ? WLB2 : WLB)      n_wlb++;
        @(negedge clk);
        lat++;
      end
    end
  endtask

  int lat, np, nw, nb, acc, acc_cyc0, acc_cyc1, rsps;
  logic rd, er;

  initial begin
    bus.req_valid = 1'b0;  bus.req_we = 1'b0;  bus.req_wdata = 1'b0;
    bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_wdata = 1'b0;

    // Reset values
    #12;
    check("rst_preb", preb, 0);
    check("rst_wl_wlb_wen_sae", {WL, WLB, w_en, SAE, write_bit}, 0);
    check("rst_ready", bus.req_ready, 1);
    check("rst_rsp", {bus.rsp_valid, bus.rsp_rdata, bus.rsp_err}, 0);
    @(negedge clk); rst_n = 1'b1;

    // Write 0, cycle by cycle
    start(1'b0, 1'b1, 1'b0);
    check("w0_t1_preb", preb, 0);
    check("w0_t1_ready", bus.req_ready, 0);
    check("w0_t1_wl", {WL, WLB, w_en}, 0);
    @(negedge clk);
    check("w0_t2_pins", {preb, WL, WLB, w_en, SAE}, 5'b11110);
    check("w0_t2_wbit", write_bit, 0);
    @(negedge clk);
    check("w0_t3_rsp", {bus.rsp_valid, bus.rsp_rdata, bus.rsp_err}, 3'b100);
    check("w0_t3_preb", preb, 0);
    @(negedge clk);
    check("w0_t4_idle", {bus.req_ready, bus.rsp_valid}, 2'b10);

    // Write 1
    start(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("w1_t2_wbit", write_bit, 1);
    @(negedge clk);
    check("w1_t3_rsp", bus.rsp_valid, 1);
    check("w1_t3_wbit_clr", write_bit, 0);
    @(negedge clk);

    // Read of stored 1
    start(1'b0, 1'b0, 1'b0);
    check("r1_t1_pins", {preb, WL, WLB, SAE}, 0);
    @(negedge clk);
    check("r1_t2_pins", {preb, WL, WLB, w_en, SAE}, 5'b11001);
    wait_rsp(1'b0, lat, np, nw, nb);
    lat++;
    check("r1_lat", lat, RD_LAT);
    check("r1_rdata", bus.rsp_rdata, 1);
    check("r1_err", bus.rsp_err, 0);
    check("r1_wlb_cycles", nb, DUAL ? 1 : 0);
    @(negedge clk);

    // Read with sense amp stuck at 1
    force_one = 1'b1;
    start(1'b0, 1'b0, 1'b0);
    wait_rsp(1'b0, lat, np, nw, nb);
    check("rf_lat", lat, RD_LAT);
    check("rf_rdata", bus.rsp_rdata, 1);
    check("rf_err", bus.rsp_err, DUAL ? 1 : 0);
    force_one = 1'b0;
    @(negedge clk);

    // Write 0 then read 0
    start(1'b0, 1'b1, 1'b0);
    wait_rsp(1'b0, lat, np, nw, nb);
    check("w0b_lat", lat, 3);
    check("w0b_rdata", bus.rsp_rdata, 0);
    @(negedge clk);
    start(1'b0, 1'b0, 1'b0);
    wait_rsp(1'b0, lat, np, nw, nb);
    check("r0_rdata", bus.rsp_rdata, 0);
    check("r0_err", bus.rsp_err, 0);
    @(negedge clk);

    // Longer phases: PRE_CYC=3, WR_CYC=2
    start(1'b1, 1'b1, 1'b1);
    wait_rsp(1'b1, lat, np, nw, nb);
    check("long_lat", lat, 6);
    check("long_pre_cycles", np, 3);
    check("long_wen_cycles", nw, 2);
    @(negedge clk);

    // req_valid held through an access: second accept only after IDLE
    acc = 0; rsps = 0; acc_cyc0 = 0; acc_cyc1 = 0;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_wdata = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (bus.rsp_valid) rsps++;
      if (acc == 2) bus.req_valid = 1'b0;
      if (bus.req_valid && bus.req_ready) begin
        if (acc == 0) acc_cyc0 = c; else acc_cyc1 = c;
        acc++;
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    check("held_accepts", acc, 2);
    check("held_gap", acc_cyc1 - acc_cyc0, 4);
    check("held_rsps", rsps, 2);

    // Reset asserted during RD_Q
    start(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("mid_sae_before", SAE, 1);
    rst_n = 1'b0;
    #1;
    check("mid_pins", {preb, WL, WLB, w_en, SAE}, 0);
    check("mid_ready", bus.req_ready, 1);
    check("mid_rsp", bus.rsp_valid, 0);
    @(negedge clk); rst_n = 1'b1;
    rsps = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.rsp_valid) rsps++;
      @(negedge clk);
    end
    check("mid_no_rsp", rsps, 0);
    start(1'b0, 1'b0, 1'b0);
    wait_rsp(1'b0, lat, np, nw, nb);
    check("post_rst_lat", lat, RD_LAT);
    check("post_rst_rdata", bus.rsp_rdata, 1);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
